// File: rtl/step_cmd_rx_if.sv
// step_cmd_rx_if: UART command line in, stepper drive out.
// ftdi_rx: host->device; step/dir/pos/busy/err: device->host.
interface step_cmd_rx_if #(
  parameter int W = 16
);
  logic         ftdi_rx;
  logic         step;
  logic         dir;
  logic [W-1:0] pos;
  logic         busy;
  logic         err;

  modport master (
    output ftdi_rx,
    input  step, dir, pos, busy, err
  );

  modport slave (
    input  ftdi_rx,
    output step, dir, pos, busy, err
  );
endinterface

// File: rtl/step_cmd_rx.sv
// step_cmd_rx: 8N1 UART hex-position parser driving a step/dir motor.
// hwclk/rst: clock, sync active-high reset; bus: rx in, step/dir/pos/busy/err out.
module step_cmd_rx #(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 9600,
  parameter int NIBBLES   = 4,
  parameter int DIR_SETUP = 12,
  parameter int STEP_HIGH = 24,
  parameter int STEP_LOW  = 24
) (
  input logic          hwclk,
  input logic          rst,
  step_cmd_rx_if.slave bus
);
  localparam int W       = 4 * NIBBLES;
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int BW      = $clog2(BIT_CYC + 1);
  localparam int CW      = $clog2(NIBBLES + 1);
  localparam int TM0     = (DIR_SETUP > STEP_HIGH) ? DIR_SETUP : STEP_HIGH;
  localparam int TMAX    = (TM0 > STEP_LOW) ? TM0 : STEP_LOW;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_st_e;

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW
  } st_e;

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  rx_st_e        rx_st_q, rx_st_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    shr_q, shr_d;
  logic          bvld_q, bvld_d;
  logic          fr_err;

  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          disc_q, disc_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic          p_err;
  logic          is_hex;
  logic [3:0]    nib;
  logic          is_lf, skip, take;

  st_e           st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  pos_q, pos_d;
  logic [W-1:0]  diff;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  // hex digit decode of the last received byte
  always_comb begin
    is_hex = 1'b1;
    nib    = '0;
    unique case (1'b1)
      (shr_q >= 8'h30 && shr_q <= 8'h39):
        nib = 4'(shr_q - 8'h30);
      (shr_q >= 8'h41 && shr_q <= 8'h46):
        nib = 4'(shr_q - 8'h37);
      (shr_q >= 8'h61 && shr_q <= 8'h66):
        nib = 4'(shr_q - 8'h57);
      default: is_hex = 1'b0;
    endcase
  end

  always_comb begin
    rx_st_d = rx_st_q;
    bcnt_d  = bcnt_q;
    nbit_d  = nbit_q;
    shr_d   = shr_q;
    bvld_d  = 1'b0;
    fr_err  = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_st_d = R_START;
          bcnt_d  = '0;
        end
      end
      R_START: begin
        if (bcnt_q == BW'(HALF - 1)) begin
          bcnt_d  = '0;
          nbit_d  = '0;
          // glitch shorter than half a bit: not a start bit
          rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (bcnt_q == BW'(BIT_CYC - 1)) begin
          bcnt_d = '0;
          shr_d  = {rx_s2_q, shr_q[7:1]};
          nbit_d = nbit_q + 1'b1;
          if (nbit_q == 3'd7) rx_st_d = R_STOP;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (bcnt_q == BW'(BIT_CYC - 1)) begin
          bcnt_d = '0;
          if (rx_s2_q) begin
            bvld_d  = 1'b1;
            rx_st_d = R_IDLE;
          end else begin
            fr_err  = 1'b1;
            rx_st_d = R_WAIT;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      R_WAIT: begin
        if (rx_s2_q) rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // parser: one byte per bvld_q strobe; shr_q is stable then
  assign is_lf = (shr_q == 8'h0A);
  assign skip  = !is_lf && (disc_q || shr_q == 8'h0D);
  assign take  = !is_lf && !skip && is_hex &&
                 (dcnt_q != CW'(NIBBLES));

  always_comb begin
    acc_d  = acc_q;
    dcnt_d = dcnt_q;
    disc_d = disc_q;
    tgt_d  = tgt_q;
    p_err  = 1'b0;
    if (bvld_q) begin
      unique case (1'b1)
        is_lf: begin
          if (!disc_q && dcnt_q == CW'(NIBBLES))
            tgt_d = acc_q;
          else if (!disc_q)
            p_err = 1'b1;
          acc_d  = '0;
          dcnt_d = '0;
          disc_d = 1'b0;
        end
        skip: acc_d = acc_q;
        take: begin
          acc_d  = (acc_q << 4) | W'(nib);
          dcnt_d = dcnt_q + 1'b1;
        end
        default: begin
          p_err  = 1'b1;
          disc_d = 1'b1;
          acc_d  = '0;
          dcnt_d = '0;
        end
      endcase
    end
  end

  assign diff = tgt_q - pos_q;

  always_comb begin
    st_d   = st_q;
    tmr_d  = tmr_q;
    step_d = step_q;
    dir_d  = dir_q;
    pos_d  = pos_q;
    unique case (st_q)
      S_IDLE: begin
        if (tgt_q != pos_q) begin
          // shortest way round; a half-turn tie goes down
          dir_d = !diff[W-1];
          tmr_d = '0;
          st_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_q == TW'(DIR_SETUP - 1)) begin
          tmr_d  = '0;
          step_d = 1'b1;
          pos_d  = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
          st_d   = S_HIGH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (tmr_q == TW'(STEP_HIGH - 1)) begin
          tmr_d  = '0;
          step_d = 1'b0;
          st_d   = S_LOW;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LOW: begin
        if (tmr_q == TW'(STEP_LOW - 1)) begin
          tmr_d = '0;
          st_d  = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    endcase
    busy_d = (st_d != S_IDLE) || (tgt_d != pos_d);
    err_d  = fr_err | p_err;
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
      rx_st_q <= R_IDLE;
      bcnt_q  <= '0;
      nbit_q  <= '0;
      shr_q   <= '0;
      bvld_q  <= 1'b0;
      acc_q   <= '0;
      dcnt_q  <= '0;
      disc_q  <= 1'b0;
      tgt_q   <= '0;
      st_q    <= S_IDLE;
      tmr_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_s1_q <= bus.ftdi_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      rx_st_q <= rx_st_d;
      bcnt_q  <= bcnt_d;
      nbit_q  <= nbit_d;
      shr_q   <= shr_d;
      bvld_q  <= bvld_d;
      acc_q   <= acc_d;
      dcnt_q  <= dcnt_d;
      disc_q  <= disc_d;
      tgt_q   <= tgt_d;
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.pos  = pos_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;
endmodule
